// File: rtl/mux_scan_nx1.sv
// rtl/mux_scan_nx1.sv - N-channel registered mux with manual select and auto-scan rotation
// Scan mode dwells DWELL cycles per enabled channel, then moves to the next enabled one upward.
module mux_scan_nx1 #(
    parameter  int N_CH  = 4,
    parameter  int W     = 4,
    parameter  int DWELL = 8,
    localparam int SEL_W = (N_CH < 2) ? 1 : $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_CH-1:0]   ch_en,
    input  logic [N_CH*W-1:0] mux_inp,
    output logic [W-1:0]      mux_op,
    output logic [SEL_W-1:0]  mux_ch,
    output logic              mux_vld,
    output logic              ch_adv
);
    localparam int NP    = 1 << SEL_W;
    localparam int CNT_W = $clog2(DWELL);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAN, S_SCAN} state_t;

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [SEL_W-1:0] nxt_ch, srch_ch;
    logic [W-1:0]     nxt_op;
    logic             nxt_vld, sel_ok;
    logic [NP-1:0]    en_ext;
    logic [W-1:0]     data_ext [NP];

    // Padding to a power of two keeps out-of-range selects safe to index.
    always_comb begin
        en_ext           = '0;
        en_ext[N_CH-1:0] = ch_en;
        for (int i = 0; i < NP; i++) data_ext[i] = '0;
        for (int i = 0; i < N_CH; i++) data_ext[i] = mux_inp[i*W +: W];
    end

    assign sel_ok = (int'(sel) < N_CH) && en_ext[sel];

    // Next enabled channel above mux_ch, wrapping; lands on mux_ch itself if it is the only one.
    always_comb begin
        logic found;
        int   idx;
        srch_ch = mux_ch;
        found   = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(mux_ch) + k) % N_CH;
            if (!found && ch_en[idx]) begin
                srch_ch = SEL_W'(idx);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_ch    = mux_ch;
        nxt_op    = '0;
        nxt_vld   = 1'b0;
        nxt_cnt   = '0;
        case (state)
            S_IDLE: nxt_state = mode ? S_SCAN : S_MAN;
            S_MAN: begin
                if (mode) nxt_state = S_SCAN;
                if (sel_ok) begin
                    nxt_ch  = sel;
                    nxt_op  = data_ext[sel];
                    nxt_vld = 1'b1;
                end
            end
            S_SCAN: begin
                if (!mode) nxt_state = S_MAN;
                if (ch_en != '0) begin
                    nxt_op  = data_ext[mux_ch];
                    nxt_vld = en_ext[mux_ch];
                    // A pending mode drop suppresses the advance and restarts the counter.
                    if (mode) begin
                        if (!en_ext[mux_ch] || cnt == LAST) nxt_ch = srch_ch;
                        else nxt_cnt = cnt + 1'b1;
                    end
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mux_ch  <= '0;
            mux_op  <= '0;
            mux_vld <= 1'b0;
            ch_adv  <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            mux_ch  <= nxt_ch;
            mux_op  <= nxt_op;
            mux_vld <= nxt_vld;
            ch_adv  <= (nxt_ch != mux_ch);
        end
    end
endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb/tb_mux_scan_nx1.sv - directed scoreboard bench for mux_scan_nx1 (4x4 default and 3x8 instance)
module tb_mux_scan_nx1;
    logic        clk = 1'b0;
    logic        rst, mode;
    logic [1:0]  sel;
    logic [3:0]  ch_en;
    logic [15:0] mux_inp;
    logic [3:0]  mux_op;
    logic [1:0]  mux_ch;
    logic        mux_vld, ch_adv;

    logic        rst3, mode3;
    logic [1:0]  sel3;
    logic [2:0]  en3;
    logic [23:0] inp3;
    logic [7:0]  op3;
    logic [1:0]  ch3;
    logic        vld3, adv3;

    always #5 clk = ~clk;

    mux_scan_nx1 #(.N_CH(4), .W(4), .DWELL(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .ch_en(ch_en), .mux_inp(mux_inp),
        .mux_op(mux_op), .mux_ch(mux_ch), .mux_vld(mux_vld), .ch_adv(ch_adv)
    );

    mux_scan_nx1 #(.N_CH(3), .W(8), .DWELL(2)) dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3), .ch_en(en3), .mux_inp(inp3),
        .mux_op(op3), .mux_ch(ch3), .mux_vld(vld3), .ch_adv(adv3)
    );

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;

    function automatic logic [31:0] obs(int s);
        case (s)
            0:       return 32'(mux_op);
            1:       return 32'(mux_ch);
            2:       return 32'(mux_vld);
            3:       return 32'(ch_adv);
            4:       return 32'(op3);
            5:       return 32'(ch3);
            6:       return 32'(vld3);
            default: return 32'(adv3);
        endcase
    endfunction

    task automatic push(string tag, int sig, logic [31:0] e);
        sb.push_back('{tag, sig, e});
    endtask

    task automatic push4(string tag, logic [31:0] op, logic [31:0] ch, logic [31:0] vld, logic [31:0] adv);
        push({tag, "_op"}, 0, op);
        push({tag, "_ch"}, 1, ch);
        push({tag, "_vld"}, 2, vld);
        push({tag, "_adv"}, 3, adv);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            assert (obs(e.sig) === e.exp) passed++;
            else begin
                fails++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs(e.sig), e.exp);
            end
        end
    endtask

    initial begin
        int segs[3];
        int data4[4];
        int prev;
        segs  = '{2, 3, 0};
        data4 = '{'hA, 'hB, 'hC, 'hD};

        rst = 1; mode = 0; sel = 0; ch_en = 4'b1111; mux_inp = 16'hDCBA;
        rst3 = 1; mode3 = 0; sel3 = 0; en3 = 3'b111; inp3 = 24'h332211;
        tick();
        push4("reset", 0, 0, 0, 0);
        push("reset3_op", 4, 0); push("reset3_vld", 6, 0);
        tick();

        rst = 0; sel = 2;
        push4("idle", 0, 0, 0, 0);
        tick();
        push4("man_sel2", 'hC, 2, 1, 1);
        tick();
        push4("man_hold", 'hC, 2, 1, 0);
        tick();

        ch_en = 4'b1011;
        push4("man_dis", 0, 2, 0, 0);
        tick();

        sel = 0; ch_en = 4'b1111;
        push4("man_sel0", 'hA, 0, 1, 1);
        tick();

        ch_en = 4'b1101; mode = 1;
        push4("to_scan", 'hA, 0, 1, 0);
        tick();
        prev = 0;
        for (int s = 0; s < 3; s++) begin
            for (int c = 1; c <= 8; c++) begin
                push("scan_ch", 1, (c == 8) ? segs[s] : prev);
                push("scan_adv", 3, (c == 8));
                if (c == 4) begin
                    push("scan_op", 0, data4[prev]);
                    push("scan_vld", 2, 1);
                end
                tick();
            end
            prev = segs[s];
        end

        for (int c = 1; c <= 8; c++) begin
            if (c == 8) push("to_ch2", 1, 2);
            tick();
        end
        for (int c = 1; c <= 3; c++) tick();
        ch_en = 4'b1001;
        push("middis_ch", 1, 3); push("middis_adv", 3, 1);
        tick();
        for (int c = 1; c <= 8; c++) begin
            push("middis_cnt_ch", 1, (c == 8) ? 0 : 3);
            push("middis_cnt_adv", 3, (c == 8));
            tick();
        end

        ch_en = 4'b0000;
        push4("none_en", 0, 0, 0, 0);
        tick();
        push("none_frozen", 1, 0);
        tick();

        ch_en = 4'b1000;
        push("to_ch3", 1, 3); push("to_ch3_adv", 3, 1);
        tick();
        for (int c = 1; c <= 5; c++) begin
            push("dwell_ch3", 1, 3);
            tick();
        end
        rst = 1;
        push4("midscan_rst", 0, 0, 0, 0);
        tick();
        rst = 0; ch_en = 4'b1011;
        push4("idle_after_rst", 0, 0, 0, 0);
        tick();
        for (int c = 1; c <= 7; c++) begin
            push("pre_expiry_ch", 1, 0);
            push("pre_expiry_adv", 3, 0);
            if (c == 3) begin
                push("pre_expiry_op", 0, 'hA);
                push("pre_expiry_vld", 2, 1);
            end
            tick();
        end
        mode = 0; sel = 1;
        push("expiry_modechg_ch", 1, 0); push("expiry_modechg_adv", 3, 0);
        tick();
        push4("man_after_scan", 'hB, 1, 1, 1);
        tick();

        rst3 = 0; sel3 = 1;
        tick();
        push("p3_sel1_op", 4, 'h22); push("p3_sel1_ch", 5, 1);
        push("p3_sel1_vld", 6, 1);   push("p3_sel1_adv", 7, 1);
        tick();
        sel3 = 3;
        push("p3_sel3_vld", 6, 0); push("p3_sel3_op", 4, 0); push("p3_sel3_ch", 5, 1);
        tick();
        mode3 = 1;
        push("p3_toscan_vld", 6, 0);
        tick();
        push("p3_scan1_op", 4, 'h22); push("p3_scan1_vld", 6, 1); push("p3_scan1_ch", 5, 1);
        tick();
        push("p3_adv_ch", 5, 2); push("p3_adv_adv", 7, 1);
        tick();
        push("p3_dwell_ch", 5, 2); push("p3_dwell_op", 4, 'h33);
        tick();
        push("p3_wrap_ch", 5, 0); push("p3_wrap_adv", 7, 1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mux_scan_nx1.md
Name: mux_scan_nx1

Overview:
Parametrised N-channel, W-bit multiplexer with a registered output. It is the successor to the single-bit 2:1 gate-level mux. It adds a manual-select mode and an auto-scan mode. In auto-scan mode the output dwells a fixed number of cycles on each enabled channel, then rotates. Typical use: time-multiplexing switch banks or data nibbles onto one display or LED group.

Parameters:
N_CH, 4, number of input channels (2..16)
W, 4, data width per channel in bits (1..32)
DWELL, 8, clock cycles spent on each channel in scan mode (>=2)
SEL_W, clog2(N_CH) (min 1), width of channel index signals (derived)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
mode  input  1  0 = manual select, 1 = auto-scan
sel  input  SEL_W  manual channel select
ch_en  input  N_CH  per-channel enable mask; bit i enables channel i
mux_inp  input  N_CH*W  packed channel data; channel i = bits [i*W+W-1 : i*W]
mux_op  output  W  registered selected data
mux_ch  output  SEL_W  index of the channel currently driving mux_op
mux_vld  output  1  high when mux_op carries data from an enabled channel
ch_adv  output  1  one-cycle pulse on each cycle where mux_ch changes value

Behaviour:
- One clock, clk. rst is synchronous and active-high, sampled on the rising edge, and overrides all other inputs, including mid-scan.
- Reset values:
  - mux_op=0, mux_ch=0, mux_vld=0, ch_adv=0
  - dwell counter=0
  - FSM=S_IDLE
- FSM states:
  - S_IDLE: entered only from reset. Leaves on the next cycle to S_MAN (mode=0) or S_SCAN (mode=1). Outputs hold their reset values while in S_IDLE.
  - S_MAN: stays while mode=0; goes to S_SCAN when mode=1.
  - S_SCAN: stays while mode=1; goes to S_MAN when mode=0.
- Latency: all outputs are registered. mux_op reflects mux_inp and the select decision of the previous edge (1 cycle latency).
- S_MAN:
  - If sel<N_CH and ch_en[sel]=1: mux_ch<=sel, mux_op<=channel sel data, mux_vld<=1.
  - Otherwise (out-of-range sel, possible when N_CH is not a power of 2, or a disabled channel): mux_ch holds, mux_op<=0, mux_vld<=0.
  - The dwell counter is held at 0.
- S_SCAN:
  - mux_op<=live data of channel mux_ch every cycle. mux_vld<=ch_en[mux_ch].
  - The dwell counter counts 0..DWELL-1.
  - On the cycle the counter equals DWELL-1: mux_ch advances to the next enabled channel, searching upward from mux_ch+1 modulo N_CH (wrap-around N_CH-1 -> 0). The counter then resets to 0.
  - Current channel disabled mid-dwell: advance on the next edge regardless of the counter, and reset the counter.
  - Exactly one enabled channel: mux_ch stays on it; the counter still wraps; no ch_adv.
  - No enabled channel: mux_ch holds, mux_op<=0, mux_vld<=0, counter held at 0.
- Mode switch:
  - S_MAN->S_SCAN: scanning starts from the current mux_ch with the counter at 0. The first advance comes DWELL cycles later.
  - S_SCAN->S_MAN: follows sel from the first S_MAN cycle.
- ch_adv=1 for exactly one cycle whenever the registered mux_ch differs from its previous value, in either mode. It is never asserted in S_IDLE or on the reset edge.
- Simultaneous events: mode change and counter expiry on the same edge -> the mode change wins (no advance). ch_en change and counter expiry on the same edge -> the new ch_en is used for the search.
- No combinational path from any input to any output.

Test Plan:
- Reset, then manual select: rst high 2 cycles, then mode=0, ch_en=4'b1111, mux_inp=16'hDCBA, sel=2 -> one cycle after S_MAN entry: mux_op=4'hC, mux_ch=2, mux_vld=1, ch_adv=1 for that one cycle only.
- Disabled channel in manual mode: ch_en=4'b1011, sel=2 -> mux_op=0, mux_vld=0, mux_ch holds its previous value, ch_adv=0.
- Auto-scan with skip and wrap: mode=1, ch_en=4'b1101, starting mux_ch=0, DWELL=8 -> mux_ch sequence 0,2,3,0,... with each channel held exactly 8 cycles. ch_adv pulses once per change. mux_op tracks 4'hA, 4'hC, 4'hD.
- Mid-dwell disable: scanning on ch 2 at counter=3, clear ch_en[2] -> next edge mux_ch=3, counter=0, ch_adv=1. With ch_en=0 entirely: mux_vld=0, mux_op=0, mux_ch frozen.
- Reset mid-scan and mode change at expiry: assert rst while at counter=5 on ch 3 -> next edge all outputs=0 and FSM=S_IDLE. Separately, drop mode on the counter=7 edge -> no advance, and mux_ch follows sel next cycle.
- Parameter sweep: N_CH=3, W=8 -> sel=3 gives mux_vld=0. Scan wraps 2->0. The packed slice for ch 1 is bits [15:8].
